imem_uart_loader: RTL
=====================

Name: imem_uart_loader

Overview:
- Writer side of the instruction memory. It receives a framed byte stream from the UART receiver and assembles little-endian 32-bit instruction words.
- It issues one-cycle word writes into the writable instruction RAM that the CPU fetch path reads via addr[31:2].
- It holds the CPU in reset until a complete, checksum-valid image has been loaded.
- It sits between uart_rx and the instruction RAM write port; its cpu_hold output gates the core reset.

Parameters:
DEPTH, 64, instruction memory depth in 32-bit words (max word count accepted)
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 1_000_000, max clk cycles allowed between bytes once a frame has started

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (reset==0 clears all state immediately)
rx_data  input  8  received byte from uart_rx
rx_valid  input  1  one-cycle strobe, rx_data valid this cycle
we  output  1  instruction RAM write enable, one-cycle pulse per word
waddr  output  32  byte address of write, always word aligned (waddr[1:0]=0)
wdata  output  32  instruction word {b3,b2,b1,b0}
cpu_hold  output  1  1 = keep CPU in reset
done  output  1  image loaded and checksum matched (sticky)
error  output  1  frame rejected (count, checksum or timeout)

Behaviour:
- Frame format: SYNC_BYTE, N (1 byte, word count), 4*N data bytes (LSB first per word), CHK byte = XOR of all 4*N data bytes.
- Reset values: we=0, waddr=0, wdata=0, cpu_hold=1, done=0, error=0; state=IDLE; byte, word and timeout counters=0; checksum=0.
- States and transitions:
  - IDLE: wait for rx_valid with rx_data==SYNC_BYTE; other bytes are ignored. Go to COUNT; clear checksum and counters; clear error.
  - COUNT: on rx_valid, latch N. N==0 or N>DEPTH -> ERROR. Otherwise -> DATA.
  - DATA: each rx_valid shifts the byte into its lane (byte_idx 0..3) and XORs it into checksum.
    - On the 4th byte: next cycle we=1 for exactly one cycle, waddr=word_idx*4, wdata=assembled word. word_idx then increments and byte_idx wraps to 0.
    - After word N-1 is written -> CHECK.
  - CHECK: on rx_valid, rx_data==checksum -> DONE, otherwise -> ERROR.
  - DONE: done=1, cpu_hold=0. Sticky until reset; all rx bytes ignored, including SYNC_BYTE.
  - ERROR: error=1, cpu_hold=1. A SYNC_BYTE restarts the frame (-> COUNT, error cleared). Words already written remain in RAM and are overwritten by the retry.
- cpu_hold=1 in every state except DONE; it deasserts the cycle DONE is entered.
- Timeout: the counter runs in COUNT/DATA/CHECK, clears on every rx_valid, and reaches TIMEOUT_CYCLES -> ERROR. The counter is sized $clog2(TIMEOUT_CYCLES+1).
- Latency: last data byte strobe at cycle t -> we high at t+1. Back-to-back rx_valid on consecutive cycles must be accepted without loss. A SYNC-valued byte inside DATA is treated as data.
- The write of the last word and a CHECK-byte rx_valid in the following cycle must both be honoured.
- Reset asserted mid-frame: immediate return to reset values, we drops asynchronously, and the partial image is left in RAM.
- Widths:
  - word_idx is $clog2(DEPTH+1) bits.
  - waddr = {word_idx, 2'b00} zero-extended to 32 bits.
  - The N comparison is unsigned.

Decomposition:
- Package imem_loader_pkg holds the state enum (IDLE, COUNT, DATA, CHECK, DONE, ERROR) and the default SYNC_BYTE constant.
- One natural sub-module: byte_to_word_packer (byte lane shift, byte_idx counter, word_ready pulse). FSM, checksum and timeout stay in the top.

Test Plan:
- Normal load: A5, 02, 33 03 52 00, B3 84 21 40, CHK=XOR(all 8) -> we pulses twice: (waddr 0, wdata 0x00520333), (waddr 4, wdata 0x402184B3); done=1, cpu_hold=0, error=0.
- Bad checksum: same frame with CHK^0x01 -> both writes occur, error=1, cpu_hold=1, done=0. Retry with a correct frame -> done=1.
- Illegal count: A5, 00 -> error=1, no we. A5, 41 (65>DEPTH) -> error=1, no we.
- Timeout: A5, 01, two data bytes, then idle TIMEOUT_CYCLES (bench overrides to 100) -> error=1 at cycle 100 after the last byte, no we.
- Garbage before sync plus back-to-back strobes: 00 FF 12, then A5 01 13 00 00 00 13 on consecutive-cycle rx_valid -> one write (waddr 0, wdata 0x00000013), done=1.
- Reset mid-DATA: after 5 data bytes of an N=2 frame, pulse reset low -> all outputs at reset values. A following full frame loads correctly.

Source files
------------

// File: rtl/imem_uart_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
// The FSM state encoding and the default frame start marker live here.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/imem_uart_loader_if.sv
// Byte stream from uart_rx plus the instruction RAM word-write port.
// The master modport is the loader; the slave modport is the environment (rx source and RAM).
interface imem_uart_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;

  modport master (
    input  rx_data,
    input  rx_valid,
    output we,
    output waddr,
    output wdata
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  we,
    input  waddr,
    input  wdata
  );
endinterface

// File: rtl/imem_uart_loader_packer.sv
// Packs LSB-first bytes into 32-bit words; word_ready pulses the cycle after the 4th byte.
// The lane register shifts right so that after three bytes it holds {b2,b1,b0}.
module byte_to_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clr,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic        o_last_lane,
  output logic        o_word_ready,
  output logic [31:0] o_word
);

  logic [1:0]  r_byte_idx;
  logic [23:0] r_lanes;
  logic        r_word_ready;
  logic [31:0] r_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_byte_idx   <= 2'd0;
      r_lanes      <= 24'd0;
      r_word_ready <= 1'b0;
      r_word       <= 32'd0;
    end else begin
      r_word_ready <= 1'b0;
      if (i_clr) begin
        r_byte_idx <= 2'd0;
        r_lanes    <= 24'd0;
      end else if (i_valid) begin
        if (r_byte_idx == 2'd3) begin
          r_word       <= {i_data, r_lanes};
          r_word_ready <= 1'b1;
          r_byte_idx   <= 2'd0;
        end else begin
          r_lanes    <= {i_data, r_lanes[23:8]};
          r_byte_idx <= r_byte_idx + 2'd1;
        end
      end
    end
  end

  assign o_last_lane  = (r_byte_idx == 2'd3);
  assign o_word_ready = r_word_ready;
  assign o_word       = r_word;

endmodule

// File: rtl/imem_uart_loader.sv
// Loads a framed, XOR-checksummed image from UART into instruction RAM and
// holds the CPU in reset until a complete valid image has been written.
//
// state | meaning
// IDLE  | waiting for the sync byte, other bytes dropped
// COUNT | next byte is the word count N
// DATA  | collecting 4*N data bytes, one RAM write per word
// CHECK | next byte is compared against the running XOR
// DONE  | image accepted, CPU released, input ignored until reset
// ERROR | frame rejected, a sync byte starts a retry
module imem_uart_loader
  import imem_loader_pkg::*;
#(
  parameter int         DEPTH          = 64,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                reset,
  imem_uart_loader_if.master  bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                error
);

  localparam int WIDX  = $clog2(DEPTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t          r_state;
  logic [WIDX-1:0] r_word_idx;
  logic [WIDX-1:0] r_n;
  logic [7:0]      r_chk;
  logic [TMO_W-1:0] r_tmo;
  logic [31:0]     r_waddr;
  logic            r_cpu_hold;
  logic            r_done;
  logic            r_error;

  logic w_is_sync;
  logic w_start;
  logic w_n_bad;
  logic w_in_frame;
  logic w_last_lane;
  logic w_word_ready;
  logic [31:0] w_word;

  assign w_is_sync  = bus.rx_valid && (bus.rx_data == SYNC_BYTE);
  assign w_start    = w_is_sync && ((r_state == IDLE) || (r_state == ERROR));
  assign w_n_bad    = (bus.rx_data == 8'd0) || (32'(bus.rx_data) > 32'(DEPTH));
  assign w_in_frame = (r_state == COUNT) || (r_state == DATA) || (r_state == CHECK);

  byte_to_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .i_clr        (w_start),
    .i_valid      (bus.rx_valid && (r_state == DATA)),
    .i_data       (bus.rx_data),
    .o_last_lane  (w_last_lane),
    .o_word_ready (w_word_ready),
    .o_word       (w_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_word_idx <= '0;
      r_n        <= '0;
      r_chk      <= 8'd0;
      r_tmo      <= '0;
      r_waddr    <= 32'd0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      if (w_in_frame && !bus.rx_valid) r_tmo <= r_tmo + TMO_W'(1);
      else                             r_tmo <= '0;

      case (r_state)
        IDLE, ERROR: begin
          if (w_start) begin
            r_state    <= COUNT;
            r_chk      <= 8'd0;
            r_word_idx <= '0;
            r_error    <= 1'b0;
          end
        end
        COUNT: begin
          if (bus.rx_valid) begin
            if (w_n_bad) begin
              r_state <= ERROR;
              r_error <= 1'b1;
            end else begin
              r_n     <= WIDX'(bus.rx_data);
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (bus.rx_valid) begin
            r_chk <= r_chk ^ bus.rx_data;
            // Move to CHECK with the last word's write so a back-to-back CHECK byte is seen.
            if (w_last_lane) begin
              r_waddr    <= 32'({r_word_idx, 2'b00});
              r_word_idx <= r_word_idx + WIDX'(1);
              if ((r_word_idx + WIDX'(1)) == r_n) r_state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == r_chk) begin
              r_state    <= DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              r_state <= ERROR;
              r_error <= 1'b1;
            end
          end
        end
        DONE:    ;
        default: r_state <= IDLE;
      endcase

      if (w_in_frame && !bus.rx_valid && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1))) begin
        r_state <= ERROR;
        r_error <= 1'b1;
        r_tmo   <= '0;
      end
    end
  end

  assign bus.we    = w_word_ready;
  assign bus.waddr = r_waddr;
  assign bus.wdata = w_word;
  assign cpu_hold  = r_cpu_hold;
  assign done      = r_done;
  assign error     = r_error;

endmodule
